hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// - Decode-stage hazard controller for the 5-stage MIPS pipeline: consumes per-instruction register
//   read/write masks (bit k = GPR k+1; $0 has no bit) and tracks write masks of in-flight instrs.
// - Decides each cycle whether the ID instruction issues or stalls; exposes in-flight write set
//   and per-stage hit vector for the forwarding mux select logic.
// PARAMETERS
// - DEPTH   3   in-flight stages tracked after ID (entry 0 = EX, 1 = MEM, DEPTH-1 = WB)
// - FWD_EN  1   1: full forwarding, only load-use stalls; 0: stall on any pending write
// - CNT_W   16  width of saturating stall counter
// PORTS
// - clk          in   1       single clock, rising edge
// - reset        in   1       synchronous, active-high
// - id_valid     in   1       ID holds a real instruction
// - id_rmask     in   31      registers read by ID instr
// - id_wmask     in   31      registers written by ID instr (includes $ra bit 30 for JAL)
// - id_is_load   in   1       ID instr is LW (result available end of MEM)
// - id_flush     in   1       squash ID instr (taken branch/jump); it never enters EX
// - mem_freeze   in   1       memory busy: whole pipeline holds
// - stall        out  1       hold PC and IF/ID register this cycle
// - issue        out  1       ID instr advances into EX at this edge
// - busy_mask    out  31      OR of wmask over valid entries 0..DEPTH-2
// - hit          out  DEPTH   hit[i] = entry i valid & |(id_rmask & entry i wmask)
// - stall_cnt    out  CNT_W   cycles with hazard stall, saturates at all-ones
// BEHAVIOUR
// - State: DEPTH entries {valid, wmask[30:0], is_load}; shift register, entry i -> i+1 on advance.
// - Reset: all entries invalid, wmask 0, stall_cnt 0; outputs stall=0, issue=0, busy_mask=0, hit=0
//   the cycle after reset is sampled high. Reset mid-operation discards all in-flight entries.
// - Hazard (combinational, no latency):
//   FWD_EN=1: haz = id_valid & hit[0] & entry0.is_load (load-use only).
//   FWD_EN=0: haz = id_valid & |(id_rmask & busy_mask). WB entry never hazards (RF write-through).
// - stall = mem_freeze | (haz & ~id_flush). issue = id_valid & ~id_flush & ~stall.
// - Advance edge (mem_freeze=0): entry0 <= issue ? {1, id_wmask, id_is_load} : bubble {0,0,0};
//   entry i <= entry i-1; entry DEPTH-1 retires. mem_freeze=1: all entries hold, no bubble inserted.
// - id_flush wins over haz: flushed instr neither stalls nor issues; a bubble enters EX.
// - id_flush with mem_freeze: stall=1 (freeze), entries hold; flush must be held by upstream.
// - id_valid=0: no hazard, bubble enters EX.
// - Zero masks (NOP, J) never hazard; issuing instr with id_wmask=0 creates a valid entry with no hits.
// - stall_cnt increments on cycles where haz & ~id_flush & ~mem_freeze; holds at 2^CNT_W-1.
// - Load-use with FWD_EN=1 stalls exactly 1 cycle: bubble moves load to MEM, haz drops.
// - FWD_EN=0 RAW on EX-stage producer stalls DEPTH-1 cycles.
// STRUCTURE
// - hazard_pkg: REG_MASK_W=31, RA_BIT=30, typedef struct packed {valid; wmask; is_load} sb_entry_t.
// - One sub-module: sb_shift_pipe (DEPTH-deep sb_entry_t shift reg, enable=~mem_freeze, sync clear).
// - Hazard compare, stall/issue and counter in top level; all outputs except stall_cnt combinational.
// TESTING
// - Load-use, FWD_EN=1: issue LW wmask=0x4 ($3), next ID rmask=0x4 -> stall=1 one cycle, hit=3'b001,
//   stall_cnt=1, then issue=1 with hit=3'b010.
// - ALU RAW, FWD_EN=1: ADD wmask=0x10, next rmask=0x10 -> stall=0, issue=1, hit=3'b001.
// - FWD_EN=0: ADD wmask=0x10, next rmask=0x10 -> stall 2 cycles, issue on third; WB-only hit no stall.
// - Freeze: load in EX, mem_freeze=1 for 3 cycles -> entries hold, stall=1, stall_cnt unchanged;
//   release -> load-use stall then issue.
// - Flush vs hazard: load-use hazard with id_flush=1 -> stall=0, issue=0, bubble in EX, stall_cnt held.
// - Reset mid-op: 3 entries valid, reset 1 cycle -> busy_mask=0, hit=0, stall_cnt=0;
//   JAL wmask=0x4000_0000 then rmask bit 30 -> hit[0]=1, no stall with FWD_EN=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard scoreboard: register mask width and
// the in-flight entry record carried down the EX/MEM/WB shift register.
package hazard_pkg;

  localparam int RA_BIT     = 30;
  localparam int REG_MASK_W = RA_BIT + 1;

  typedef struct packed {
    logic                  valid;
    logic [REG_MASK_W-1:0] wmask;
    logic                  is_load;
  } sb_entry_t;

  function automatic sb_entry_t make_entry(input logic [REG_MASK_W-1:0] wmask,
                                           input logic                  is_load);
    sb_entry_t e;
    e.valid   = 1'b1;
    e.wmask   = wmask;
    e.is_load = is_load;
    return e;
  endfunction

endpackage

// File: rtl/sb_shift_pipe.sv
// DEPTH-deep shift register of in-flight entries; entry 0 is EX, entry DEPTH-1 is WB.
// The whole pipe holds while en is low and clears synchronously on reset.
module sb_shift_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  sb_entry_t             din,
  output sb_entry_t [DEPTH-1:0] entries
);

  sb_entry_t [DEPTH-1:0] entries_reg;
  sb_entry_t [DEPTH-1:0] entries_next;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign entries_next[gi] = din;
      end else begin : g_body
        assign entries_next[gi] = entries_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_reg <= '0;
    end else if (en) begin
      entries_reg <= entries_next;
    end
  end

  assign entries = entries_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard controller: compares the ID read mask against in-flight
// write masks, decides stall/issue and counts hazard stall cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_MASK_W-1:0] id_rmask,
  input  logic [REG_MASK_W-1:0] id_wmask,
  input  logic                  id_is_load,
  input  logic                  id_flush,
  input  logic                  mem_freeze,
  output logic                  stall,
  output logic                  issue,
  output logic [REG_MASK_W-1:0] busy_mask,
  output logic [DEPTH-1:0]      hit,
  output logic [CNT_W-1:0]      stall_cnt
);

  sb_entry_t [DEPTH-1:0] entries;
  sb_entry_t             ex_next;
  logic                  haz;
  logic                  cnt_inc;
  logic [CNT_W-1:0]      stall_cnt_reg;
  logic                  unused_load_bits;

  sb_shift_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .en      (~mem_freeze),
    .din     (ex_next),
    .entries (entries)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit[gi] = entries[gi].valid & (|(id_rmask & entries[gi].wmask));
    end
  endgenerate

  // The WB entry is excluded: the register file writes through to the read port.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (entries[i].valid) busy_mask = busy_mask | entries[i].wmask;
    end
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      assign haz = id_valid & hit[0] & entries[0].is_load;
    end else begin : g_nofwd
      assign haz = id_valid & (|(id_rmask & busy_mask));
    end
  endgenerate

  always_comb begin
    unused_load_bits = 1'b0;
    for (int i = 0; i < DEPTH; i++) unused_load_bits = unused_load_bits ^ entries[i].is_load;
  end

  assign stall   = mem_freeze | (haz & ~id_flush);
  assign issue   = id_valid & ~id_flush & ~stall;
  assign ex_next = issue ? make_entry(id_wmask, id_is_load) : '0;

  // Freeze cycles are not hazard stalls, so they leave the counter alone.
  assign cnt_inc = haz & ~id_flush & ~mem_freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (cnt_inc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives a forwarding and a non-forwarding scoreboard from the same ID stream and
// checks both against a per-instruction model of the in-flight pipeline.
module tb_hazard_scoreboard;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [30:0] id_rmask;
  logic [30:0] id_wmask;
  logic        id_is_load;
  logic        id_flush;
  logic        mem_freeze;

  logic        f_stall, f_issue, n_stall, n_issue;
  logic [30:0] f_busy, n_busy;
  logic [D-1:0] f_hit, n_hit;
  logic [15:0] f_cnt;
  logic [2:0]  n_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(D), .FWD_EN(1), .CNT_W(16)) dut_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rmask(id_rmask),
    .id_wmask(id_wmask), .id_is_load(id_is_load), .id_flush(id_flush),
    .mem_freeze(mem_freeze), .stall(f_stall), .issue(f_issue),
    .busy_mask(f_busy), .hit(f_hit), .stall_cnt(f_cnt)
  );

  hazard_scoreboard #(.DEPTH(D), .FWD_EN(0), .CNT_W(3)) dut_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rmask(id_rmask),
    .id_wmask(id_wmask), .id_is_load(id_is_load), .id_flush(id_flush),
    .mem_freeze(mem_freeze), .stall(n_stall), .issue(n_issue),
    .busy_mask(n_busy), .hit(n_hit), .stall_cnt(n_cnt)
  );

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Model: per DUT (0 = no forwarding, 1 = forwarding), the instruction in each stage after ID.
  logic        m_v [2][D];
  logic [30:0] m_w [2][D];
  logic        m_l [2][D];
  int          m_cnt [2];
  int          m_max [2];
  logic        m_haz [2];
  logic        m_issue [2];

  logic        o_stall [2];
  logic        o_issue [2];
  logic [D-1:0] o_hit [2];
  logic [30:0] o_busy [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [30:0] r, input logic [30:0] w,
                      input logic ld, input logic fl, input logic fz);
    logic [30:0] busy;
    logic [D-1:0] hv;
    logic st;
    reset = rst; id_valid = v; id_rmask = r; id_wmask = w;
    id_is_load = ld; id_flush = fl; mem_freeze = fz;
    @(negedge clk);
    o_stall[0] = n_stall; o_issue[0] = n_issue; o_hit[0] = n_hit; o_busy[0] = n_busy;
    o_stall[1] = f_stall; o_issue[1] = f_issue; o_hit[1] = f_hit; o_busy[1] = f_busy;
    for (int k = 0; k < 2; k++) begin
      busy = '0;
      hv   = '0;
      for (int s = 0; s < D; s++) begin
        if (m_v[k][s] && (r & m_w[k][s]) != 0) hv[s] = 1'b1;
        if (m_v[k][s] && s < D - 1) busy = busy | m_w[k][s];
      end
      if (k == 1) m_haz[k] = v && hv[0] && m_l[k][0];
      else        m_haz[k] = v && ((r & busy) != 0);
      st = fz || (m_haz[k] && !fl);
      m_issue[k] = v && !fl && !st;
      check($sformatf("stall%0d", k), 32'(o_stall[k]), 32'(st));
      check($sformatf("issue%0d", k), 32'(o_issue[k]), 32'(m_issue[k]));
      check($sformatf("hit%0d", k),   32'(o_hit[k]),   32'(hv));
      check($sformatf("busy%0d", k),  32'(o_busy[k]),  32'(busy));
    end
    check("cnt0", 32'(n_cnt), 32'(m_cnt[0]));
    check("cnt1", 32'(f_cnt), 32'(m_cnt[1]));
    $display("txn %0d rst=%b v=%b r=%h w=%h ld=%b fl=%b fz=%b | fwd st=%b is=%b hit=%b | nofwd st=%b is=%b hit=%b",
             txn, rst, v, r, w, ld, fl, fz, f_stall, f_issue, f_hit, n_stall, n_issue, n_hit);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int s = 0; s < D; s++) begin m_v[k][s] = 0; m_w[k][s] = '0; m_l[k][s] = 0; end
        m_cnt[k] = 0;
      end else if (!fz) begin
        for (int s = D - 1; s > 0; s--) begin
          m_v[k][s] = m_v[k][s-1]; m_w[k][s] = m_w[k][s-1]; m_l[k][s] = m_l[k][s-1];
        end
        m_v[k][0] = m_issue[k];
        m_w[k][0] = m_issue[k] ? w : '0;
        m_l[k][0] = m_issue[k] ? ld : 1'b0;
        if (m_haz[k] && !fl && m_cnt[k] < m_max[k]) m_cnt[k]++;
      end
    end
    txn++;
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, '0, '0, 0, 0, 0);
  endtask

  initial begin
    m_max[0] = 7;
    m_max[1] = 65535;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int s = 0; s < D; s++) begin m_v[k][s] = 0; m_w[k][s] = '0; m_l[k][s] = 0; end
    end
    reset = 1; id_valid = 0; id_rmask = '0; id_wmask = '0;
    id_is_load = 0; id_flush = 0; mem_freeze = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    step(0, 0, '0, '0, 0, 0, 0);
    check("rst_stall", 32'(o_stall[1]), 32'd0);
    check("rst_issue", 32'(o_issue[1]), 32'd0);
    check("rst_busy",  32'(o_busy[1]),  32'd0);
    check("rst_hit",   32'(o_hit[1]),   32'd0);
    check("rst_cnt",   32'(f_cnt),      32'd0);

    // load-use with forwarding: one stall, then issue with MEM hit
    step(0, 1, '0, 31'h4, 1, 0, 0);
    step(0, 1, 31'h4, '0, 0, 0, 0);
    check("lu_stall", 32'(o_stall[1]), 32'd1);
    check("lu_hit",   32'(o_hit[1]),   32'b001);
    check("lu_cnt",   32'(f_cnt),      32'd1);
    step(0, 1, 31'h4, '0, 0, 0, 0);
    check("lu_issue", 32'(o_issue[1]), 32'd1);
    check("lu_hit2",  32'(o_hit[1]),   32'b010);

    // ALU RAW: forwarding issues at once, no-forwarding stalls twice
    do_reset();
    step(0, 1, '0, 31'h10, 0, 0, 0);
    step(0, 1, 31'h10, '0, 0, 0, 0);
    check("raw_f_stall", 32'(o_stall[1]), 32'd0);
    check("raw_f_issue", 32'(o_issue[1]), 32'd1);
    check("raw_f_hit",   32'(o_hit[1]),   32'b001);
    check("raw_n_st1",   32'(o_stall[0]), 32'd1);
    step(0, 1, 31'h10, '0, 0, 0, 0);
    check("raw_n_st2",   32'(o_stall[0]), 32'd1);
    step(0, 1, 31'h10, '0, 0, 0, 0);
    check("raw_n_issue", 32'(o_issue[0]), 32'd1);
    check("raw_n_wbhit", 32'(o_hit[0]),   32'b100);

    // freeze holds the load in EX without counting
    do_reset();
    step(0, 1, '0, 31'h4, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 31'h4, '0, 0, 0, 1);
      check("frz_stall", 32'(o_stall[1]), 32'd1);
      check("frz_hit",   32'(o_hit[1]),   32'b001);
    end
    check("frz_cnt", 32'(f_cnt), 32'd0);
    step(0, 1, 31'h4, '0, 0, 0, 0);
    check("frz_lu_stall", 32'(o_stall[1]), 32'd1);
    step(0, 1, 31'h4, '0, 0, 0, 0);
    check("frz_issue", 32'(o_issue[1]), 32'd1);

    // flush beats the load-use hazard
    do_reset();
    step(0, 1, '0, 31'h4, 1, 0, 0);
    step(0, 1, 31'h4, '0, 0, 1, 0);
    check("fl_stall", 32'(o_stall[1]), 32'd0);
    check("fl_issue", 32'(o_issue[1]), 32'd0);
    check("fl_cnt",   32'(f_cnt),      32'd0);
    step(0, 0, '0, '0, 0, 0, 0);
    check("fl_busy",  32'(o_busy[1]),  32'h4);

    // reset mid-operation, then JAL forwarding of $ra
    do_reset();
    step(0, 1, '0, 31'h1, 0, 0, 0);
    step(0, 1, '0, 31'h2, 0, 0, 0);
    step(0, 1, '0, 31'h4, 0, 0, 0);
    do_reset();
    step(0, 0, '0, '0, 0, 0, 0);
    check("mr_busy", 32'(o_busy[1]), 32'd0);
    check("mr_cnt",  32'(f_cnt),     32'd0);
    step(0, 1, '0, 31'h4000_0000, 0, 0, 0);
    step(0, 1, 31'h4000_0000, '0, 0, 0, 0);
    check("jal_hit",   32'(o_hit[1]),   32'b001);
    check("jal_stall", 32'(o_stall[1]), 32'd0);

    // randomized traffic over a few registers so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      logic        rr, vv, ll, ff, zz;
      logic [30:0] rm, wm;
      rr = ($urandom_range(0, 63) == 0);
      vv = ($urandom_range(0, 3) != 0);
      ff = ($urandom_range(0, 7) == 0);
      zz = ($urandom_range(0, 7) == 0);
      ll = ($urandom_range(0, 2) == 0);
      rm = 31'($urandom_range(0, 15));
      if (i % 50 == 25) rm = 31'h4000_0000;
      wm = ($urandom_range(0, 4) == 0) ? '0 : (31'h1 << $urandom_range(0, 3));
      step(rr, vv, rm, wm, ll, ff, zz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
